// File: rtl/ps2_host_tx_if.sv
// Request/response bundle between a command source and the PS/2 host transmitter.
// The source drives a byte and a request; the transmitter answers with its
// handshake state and a one-cycle completion pulse carrying the error flag.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte per transaction over the open-drain ps2_clk/ps2_data
// lines: inhibit the clock, request to send, shift the frame on device clock
// falls, check the device ACK, then wait for both lines to go idle.
// The *_oe outputs pull their line low when 1; the top level makes the tri-states.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int               INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } state_t;

    state_t           state;
    logic             clk_meta;
    logic             clk_sync;
    logic             clk_hist;
    logic             data_meta;
    logic             data_sync;
    logic             clk_fall;
    logic [9:0]       frame;
    logic [3:0]       fall_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [19:0]      to_cnt;
    logic             nack;
    logic             tx_ready_q;
    logic             done_q;
    logic             err_q;
    logic             timeout_hit;

    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = ~tx_ready_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    // A device clock fall: the previous synchronized level was high, the current one is low.
    assign clk_fall    = clk_hist & ~clk_sync;
    assign timeout_hit = (to_cnt == TO_LAST);

    // Bring the asynchronous line levels into the clock domain; idle lines read high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_hist  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_hist  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Transaction sequencer; every output is registered here so nothing leaks combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            frame       <= '0;
            fall_cnt    <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            nack        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        frame       <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        fall_cnt    <= '0;
                        inh_cnt     <= '0;
                        to_cnt      <= '0;
                        nack        <= 1'b0;
                        tx_ready_q  <= 1'b0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                ST_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    to_cnt     <= '0;
                    state      <= ST_SEND;
                end

                ST_SEND: begin
                    if (timeout_hit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_fall) begin
                            ps2_data_oe <= ~frame[fall_cnt];
                            fall_cnt    <= fall_cnt + 1'b1;
                            if (fall_cnt == 4'd9) begin
                                state <= ST_ACK;
                            end
                        end
                    end
                end

                ST_ACK: begin
                    if (timeout_hit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_fall) begin
                            nack  <= data_sync;
                            state <= ST_WAIT_IDLE;
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (timeout_hit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_sync && data_sync) begin
                            done_q <= 1'b1;
                            err_q  <= nack;
                            state  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    tx_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-based PS/2 device model clocks frames out of the
// host, and every sampled bit, handshake and timing point is compared with values
// derived from the byte being sent.
module tb_ps2_host_tx;

    localparam int INHIBIT = 10;
    localparam int TIMEOUT = 2000;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic clk_line;
    logic data_line;

    int vectors        = 0;
    int miscompares    = 0;
    int cyc            = 0;
    int done_count     = 0;
    int expected_dones = 0;

    ps2_host_tx_if bus ();

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // 50 MHz-style free-running clock.
    always #10 clock = ~clock;

    // Cycle stamp used to measure latencies.
    always @(posedge clock) cyc <= cyc + 1;

    // Count every completion pulse the DUT ever produces.
    always @(negedge clock) if (bus.done === 1'b1) done_count <= done_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference frame: data LSB first, odd parity from the ones count, stop bit high.
    function automatic logic [9:0] expectedFrame(input logic [7:0] d);
        logic [9:0] f;
        f[7:0] = d;
        f[8]   = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input bit hold_next);
        @(negedge clock);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        if (hold_next) bus.tx_data = 8'h12;
        else           bus.tx_valid = 1'b0;
        checkOutput("ready_after_accept", bus.tx_ready, 0);
        checkOutput("busy_after_accept", bus.busy, 1);
        checkOutput("clk_oe_after_accept", ps2_clk_oe, 1);
    endtask

    task automatic measureInhibit();
        int n_inh = 0;
        int n_req = 0;
        int guard = 0;
        while (ps2_clk_oe === 1'b1 && guard < 100) begin
            if (ps2_data_oe === 1'b1) n_req++;
            else                      n_inh++;
            guard++;
            @(negedge clock);
        end
        checkOutput("inhibit_cycles", n_inh, INHIBIT);
        checkOutput("req_cycles", n_req, 1);
    endtask

    task automatic runDevice(input bit give_ack, input int abort_after, input logic [9:0] exp,
                             output logic [9:0] got, output bit aborted);
        bit seen = 0;
        got     = '0;
        aborted = 0;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge clock);
            if (clk_line === 1'b1 && data_line === 1'b0) seen = 1;
        end
        checkOutput("release_seen", seen, 1);
        if (!seen) return;
        checkOutput("start_bit", data_line, 0);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            for (int j = 1; j <= 20; j++) begin
                @(negedge clock);
                if (k == 1 && j == 2) checkOutput("edge_latency_early", ps2_data_oe, 1);
                if (k == 1 && j == 3) checkOutput("edge_latency_n3", ps2_data_oe, !exp[0]);
                if (k == abort_after && j == 5) begin
                    aborted = 1;
                    return;
                end
            end
            dev_clk    = 1'b1;
            got[k-1]   = data_line;
            for (int j = 1; j <= 20; j++) begin
                @(negedge clock);
                if (k == 10 && j == 10 && give_ack) dev_data = 1'b0;
            end
        end
        dev_clk = 1'b0;
        repeat (20) @(negedge clock);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic waitDone(input int limit, output bit seen, output logic err_v, output int at);
        seen  = 0;
        err_v = 1'b0;
        at    = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                seen  = 1;
                err_v = bus.err;
                at    = cyc;
            end
        end
    endtask

    task automatic runBody(input logic [9:0] exp, input bit ack);
        logic [9:0] got;
        bit         ab;
        bit         seen;
        logic       e;
        int         at;
        measureInhibit();
        runDevice(ack, 0, exp, got, ab);
        checkOutput("frame_bits", got, exp);
        waitDone(200, seen, e, at);
        checkOutput("done_seen", seen, 1);
        checkOutput("err_flag", e, !ack);
        expected_dones++;
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] exp;
        logic [9:0] got;
        bit         ab;
        bit         ack;
        bit         seen;
        bit         seen_oe;
        logic       e;
        int         rel;
        int         oe_at;
        int         at;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rst_tx_ready", bus.tx_ready, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_clk_oe", ps2_clk_oe, 0);
        checkOutput("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] set-LEDs command 0xED");
        applyStimulus(8'hED, 0);
        runBody(expectedFrame(8'hED), 1);
        @(negedge clock);
        checkOutput("ready_return", bus.tx_ready, 1);

        $display("[TB] all-zero byte");
        applyStimulus(8'h00, 0);
        runBody(expectedFrame(8'h00), 1);
        @(negedge clock);

        $display("[TB] device NACK on 0xFF");
        applyStimulus(8'hFF, 0);
        runBody(expectedFrame(8'hFF), 0);
        @(negedge clock);

        $display("[TB] silent device, timeout");
        applyStimulus(8'hF4, 0);
        measureInhibit();
        rel     = cyc;
        seen    = 0;
        seen_oe = 0;
        oe_at   = 0;
        at      = 0;
        e       = 1'b0;
        for (int i = 0; i < TIMEOUT + 100 && !seen; i++) begin
            @(negedge clock);
            if (!seen_oe && ps2_data_oe === 1'b0) begin
                seen_oe = 1;
                oe_at   = cyc;
                checkOutput("timeout_clk_oe", ps2_clk_oe, 0);
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                e    = bus.err;
                at   = cyc;
            end
        end
        checkOutput("timeout_release_at", oe_at - rel, TIMEOUT);
        checkOutput("timeout_done_seen", seen, 1);
        checkOutput("timeout_done_window", (at - rel >= TIMEOUT) && (at - rel <= TIMEOUT + 1), 1);
        checkOutput("timeout_err", e, 1);
        expected_dones++;
        @(negedge clock);
        checkOutput("timeout_ready_return", bus.tx_ready, 1);

        $display("[TB] reset in the middle of a frame");
        d   = 8'h5A;
        exp = expectedFrame(d);
        applyStimulus(d, 0);
        measureInhibit();
        runDevice(1, 4, exp, got, ab);
        checkOutput("abort_reached", ab, 1);
        checkOutput("partial_bits", got[2:0], exp[2:0]);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_clk_oe", ps2_clk_oe, 0);
        checkOutput("midrst_data_oe", ps2_data_oe, 0);
        checkOutput("midrst_ready", bus.tx_ready, 1);
        checkOutput("midrst_done", bus.done, 0);
        dev_clk = 1'b1;
        reset   = 1'b0;
        repeat (60) @(negedge clock);

        $display("[TB] request held while busy, then back-to-back");
        applyStimulus(8'hED, 1);
        runBody(expectedFrame(8'hED), 1);
        @(negedge clock);
        checkOutput("b2b_ready_after_done", bus.tx_ready, 1);
        @(negedge clock);
        checkOutput("b2b_accepted", bus.tx_ready, 0);
        checkOutput("b2b_clk_oe", ps2_clk_oe, 1);
        bus.tx_valid = 1'b0;
        runBody(expectedFrame(8'h12), 1);
        @(negedge clock);

        $display("[TB] randomized bytes");
        for (int n = 0; n < 6; n++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            applyStimulus(d, 0);
            runBody(expectedFrame(d), ack);
            @(negedge clock);
            checkOutput("rand_ready_return", bus.tx_ready, 1);
        end

        repeat (5) @(negedge clock);
        checkOutput("total_done_pulses", done_count, expected_dones);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
